seq_det_prog: RTL and testbench
===============================

// Module: seq_det_prog
// PURPOSE
//  Run-time programmable serial bit-sequence detector with a Moore output.
//  - Pattern length 1..MAX_LEN; overlapping or non-overlapping mode selectable.
//  - Replaces fixed per-pattern FSM detectors in the FSM library.
//  - Reset defaults give "1001", non-overlapping.
//  - Sits on a 1-bit serial stream, sampled one bit per clk when en=1.
// PARAMETERS
//  MAX_LEN      8        longest supported pattern, >=2
//  LEN_W        $clog2(MAX_LEN+1)  width of length field (derived)
//  DEF_PATTERN  'b1001   pattern after reset; right-aligned, MAX_LEN bits
//  DEF_LEN      4        pattern length after reset
//  DEF_OVERLAP  0        overlap mode after reset
//  CNT_W        8        match counter width (SEQ_DET_MATCH_CNT_EN only)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-low
//  en           in   1        sample qualifier; signal sampled when en=1
//  signal       in   1        serial input bit
//  cfg_load     in   1        1-cycle strobe: latch cfg_* into active config
//  cfg_pattern  in   MAX_LEN  pattern; bit[len-1] is first bit received, bit[0] last
//  cfg_len      in   LEN_W    pattern length, legal 1..MAX_LEN
//  cfg_overlap  in   1        1=overlapping, 0=non-overlapping
//  cfg_err      out  1        1-cycle pulse: cfg_load rejected (illegal cfg_len)
//  out          out  1        Moore detect flag
//  match_cnt    out  CNT_W    saturating match count (SEQ_DET_MATCH_CNT_EN only)
// BEHAVIOUR
//  Reset (rst=0, async)
//   - Active config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
//   - hist=0, fill=0, out=0, cfg_err=0, match_cnt=0.
//  State
//   - hist: MAX_LEN-bit shift register; hist_n = {hist[MAX_LEN-2:0], signal}, newest bit at [0].
//   - fill: count of bits sampled since last clear; saturates at MAX_LEN.
//  Sample cycle (en=1, cfg_load=0)
//   - hist <= hist_n.
//   - match = (fill+1 >= len) && (hist_n[len-1:0] == pattern[len-1:0]).
//   - out <= match.
//  Latency
//   - out is high for exactly the cycle after the edge that samples the final pattern bit.
//   - Equivalent to the "detected" state of a Moore FSM; no combinational path signal->out.
//  Mode on match
//   - Non-overlapping: fill <= 0; the next match needs len fresh bits. hist is still updated.
//   - Overlapping: fill <= sat(fill+1); a pattern suffix may start the next match.
//   - On a non-match sample: fill <= sat(fill+1).
//  Idle cycle (en=0, cfg_load=0)
//   - hist and fill hold; out <= 0 (at most one out pulse per sampled bit).
//  cfg_load=1 with cfg_len in 1..MAX_LEN
//   - Active config updated; hist, fill and out cleared next cycle.
//   - Any in-progress partial match is discarded.
//  cfg_load=1 with cfg_len=0 or >MAX_LEN
//   - Config, hist and fill unchanged; out <= 0; cfg_err <= 1 for one cycle.
//  cfg_load and en in the same cycle
//   - cfg_load wins; that signal bit is discarded.
//  Pattern bits above len-1 are ignored.
//  len=1 with overlap=0 behaves the same as overlap=1.
//  rst asserted mid-sequence: immediate clear to reset state; out drops asynchronously.
// CONFIGURATION
//  SEQ_DET_MATCH_CNT_EN defined
//   - match_cnt port present.
//   - Increments on each cycle where out is set to 1; saturates at 2^CNT_W-1.
//   - Cleared on rst and on an accepted cfg_load.
//  SEQ_DET_MATCH_CNT_EN undefined
//   - match_cnt port and counter logic absent; all other behaviour identical.
// TESTING
//  1. Reset defaults, stream 1,0,0,1,0,0,1 (en=1) -> single out pulse, cycle after 4th bit.
//  2. cfg_overlap=1, len=4, pattern 1001, same stream -> out pulses after bits 4 and 7.
//  3. len=8, pattern 10110111, stream 1011011 then gap en=0 for 3 cycles then 1
//     -> no pulse during gap; pulse after the final 1.
//  4. Feed 1,0,0 then cfg_load (same config) then 1 -> no pulse. Then 1,0,0,1 -> pulse.
//  5. cfg_load with cfg_len=0 and with cfg_len=9 -> cfg_err pulses 1 cycle each; config stays 1001.
//  6. SEQ_DET_MATCH_CNT_EN, CNT_W=2, len=1, pattern 1, stream of 5 ones, overlap=1
//     -> out high 5 cycles; match_cnt = 1,2,3,3,3.

Source files
------------

// File: rtl/seq_det_prog.sv
// -----------------------------------------------------------------------------
// seq_det_prog
//   Run-time programmable serial bit-sequence detector with a Moore output.
//   One bit of signal_i is taken per clk while en_i=1. out_o is high for
//   exactly the cycle after the edge that sampled the last bit of a match.
//   The pattern (1..MAX_LEN bits, first-received bit at [len-1]), length and
//   overlap mode are loaded with a one-cycle cfg_load_i strobe. A load with an
//   illegal length is dropped and reported on cfg_err_o.
//
//   Optional feature macro: SEQ_DET_MATCH_CNT_EN
//     When defined, adds parameter CNT_W and output match_cnt_o, a saturating
//     count of detections that is cleared by reset and by an accepted load.
//
//   Valid/ready note: there is no back-pressure. en_i is a pure "sample valid"
//   qualifier and the block is always ready. cfg_load_i is a single-cycle
//   request; it is answered the next cycle either silently (accepted) or by
//   a one-cycle cfg_err_o pulse (rejected).
// -----------------------------------------------------------------------------
module seq_det_prog #(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          LEN_W       = $clog2(MAX_LEN + 1),
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'('b1001),
    parameter int unsigned          DEF_LEN     = 4,
    parameter logic                 DEF_OVERLAP = 1'b0
`ifdef SEQ_DET_MATCH_CNT_EN
    , parameter int unsigned        CNT_W       = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               signal_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    output logic               cfg_err_o,
    output logic               out_o
`ifdef SEQ_DET_MATCH_CNT_EN
    , output logic [CNT_W-1:0] match_cnt_o
`endif
);

    // Length constants sized to the length field so every compare is same-width.
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);

    // ---------------------------------------------------------------------
    // Active configuration
    // ---------------------------------------------------------------------
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               overlap_q, overlap_d;

    // ---------------------------------------------------------------------
    // Detector state
    //   hist_q : last MAX_LEN sampled bits, newest at [0]
    //   fill_q : bits sampled since the last clear, saturating at MAX_LEN;
    //            it stops a match from being formed out of stale history
    //            after a clear or after a non-overlapping hit.
    // ---------------------------------------------------------------------
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               out_q,  out_d;
    logic               err_q,  err_d;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic [MAX_LEN-1:0] hist_n;       // history including the incoming bit
    logic [MAX_LEN-1:0] len_mask;     // ones in bits [len_q-1:0]
    logic [LEN_W:0]     fill_inc;     // fill_q + 1, one bit wider (no wrap)
    logic [LEN_W-1:0]   fill_sat;     // fill_q + 1 saturated at MAX_LEN
    logic               enough_bits;  // at least len bits since last clear
    logic               match;        // incoming bit completes the pattern
    logic               cfg_ok;       // requested length is legal
    logic               cfg_accept;   // legal load this cycle
    logic               cfg_reject;   // illegal load this cycle
    logic               sample;       // a bit is actually taken this cycle
    logic               hit;          // a bit is taken and completes a match

    // The oldest history bit shifts out before it can ever be compared.
    logic               unused_hist_msb;
    assign unused_hist_msb = hist_q[MAX_LEN-1];

    // Shifted history and the length mask that hides pattern bits above len-1.
    always_comb begin
        hist_n   = {hist_q[MAX_LEN-2:0], signal_i};
        len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (i < int'(len_q)) begin
                len_mask[i] = 1'b1;
            end
        end
    end

    // Fill bookkeeping and the match decision for the incoming bit.
    always_comb begin
        fill_inc    = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        fill_sat    = (fill_q == MAX_LEN_L) ? fill_q : fill_inc[LEN_W-1:0];
        enough_bits = (fill_inc >= {1'b0, len_q});
        match       = enough_bits &&
                      ((hist_n & len_mask) == (pattern_q & len_mask));
    end

    // Classify the cycle: a load always wins over a sample in the same cycle.
    always_comb begin
        cfg_ok     = (cfg_len_i != '0) && (cfg_len_i <= MAX_LEN_L);
        cfg_accept = cfg_load_i && cfg_ok;
        cfg_reject = cfg_load_i && !cfg_ok;
        sample     = !cfg_load_i && en_i;
        hit        = sample && match;
    end

    // Next-state logic for configuration, history, fill and the two flags.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        out_d     = 1'b0;   // Moore flag is a single-cycle pulse per sample
        err_d     = 1'b0;   // error is a single-cycle pulse per rejected load

        if (cfg_accept) begin
            // New configuration; any partial match in flight is discarded.
            pattern_d = cfg_pattern_i;
            len_d     = cfg_len_i;
            overlap_d = cfg_overlap_i;
            hist_d    = '0;
            fill_d    = '0;
        end else if (cfg_reject) begin
            // Everything holds; only the error pulse is raised.
            err_d = 1'b1;
        end else if (sample) begin
            hist_d = hist_n;
            out_d  = match;
            // Non-overlapping: the next hit needs len fresh bits.
            // With len=1 this is indistinguishable from overlapping mode.
            if (match && !overlap_q) begin
                fill_d = '0;
            end else begin
                fill_d = fill_sat;
            end
        end
    end

    // State register with asynchronous active-low clear to the reset config.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= DEF_LEN_L;
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
            err_q     <= err_d;
        end
    end

    assign out_o     = out_q;
    assign cfg_err_o = err_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    // ---------------------------------------------------------------------
    // Saturating detection counter
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count each cycle that raises out; clear on an accepted load; hold at max.
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_accept) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared asynchronously with the rest of the block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt_o = cnt_q;
`else
    // Without the counter the hit strobe has no consumer.
    logic unused_hit;
    assign unused_hit = hit;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_det_prog
//   Directed, table-driven bench for seq_det_prog. Each table row is driven
//   for one clock; outputs are compared at the following falling edge.
//   Optional feature macro: SEQ_DET_MATCH_CNT_EN (checks match_cnt_o, CNT_W=2).
// -----------------------------------------------------------------------------
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
`ifdef SEQ_DET_MATCH_CNT_EN
    localparam int CNT_W   = 2;
`endif
    localparam int CNT_MAX = 3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic               en_i;
    logic               signal_i;
    logic               cfg_load_i;
    logic [MAX_LEN-1:0] cfg_pattern_i;
    logic [LEN_W-1:0]   cfg_len_i;
    logic               cfg_overlap_i;
    logic               cfg_err_o;
    logic               out_o;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt_o;
`endif

    seq_det_prog #(
        .MAX_LEN(MAX_LEN)
`ifdef SEQ_DET_MATCH_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .signal_i      (signal_i),
        .cfg_load_i    (cfg_load_i),
        .cfg_pattern_i (cfg_pattern_i),
        .cfg_len_i     (cfg_len_i),
        .cfg_overlap_i (cfg_overlap_i),
        .cfg_err_o     (cfg_err_o),
        .out_o         (out_o)
`ifdef SEQ_DET_MATCH_CNT_EN
        , .match_cnt_o (match_cnt_o)
`endif
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic       sig;
        logic       load;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       exp_out;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;
    int   exp_cnt;

    function automatic vec_t mk(input logic en, input logic sig, input logic load,
                                input logic [7:0] pat, input logic [3:0] len,
                                input logic ovl, input logic eo, input logic ee);
        vec_t v;
        v.en = en; v.sig = sig; v.load = load; v.pat = pat; v.len = len;
        v.ovl = ovl; v.exp_out = eo; v.exp_err = ee;
        return v;
    endfunction

    // sample one bit, expected out
    function automatic vec_t s(input logic sig, input logic eo);
        return mk(1'b1, sig, 1'b0, 8'h00, 4'd0, 1'b0, eo, 1'b0);
    endfunction

    // idle cycle (en=0), signal value irrelevant
    function automatic vec_t idle(input logic sig);
        return mk(1'b0, sig, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    // config load, expected error flag
    function automatic vec_t ld(input logic [7:0] pat, input logic [3:0] len,
                                input logic ovl, input logic ee);
        return mk(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0, ee);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic eo, input logic ee);
        check({tag, " out"}, int'(out_o), int'(eo));
        check({tag, " cfg_err"}, int'(cfg_err_o), int'(ee));
`ifdef SEQ_DET_MATCH_CNT_EN
        check({tag, " match_cnt"}, int'(match_cnt_o), exp_cnt);
`endif
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; drives a row, lets one rising edge consume it,
    // then compares at the next falling edge.
    task automatic run_row(input vec_t v, input int idx);
        en_i          = v.en;
        signal_i      = v.sig;
        cfg_load_i    = v.load;
        cfg_pattern_i = v.pat;
        cfg_len_i     = v.len;
        cfg_overlap_i = v.ovl;
        @(posedge clk);
        @(negedge clk);
        if (v.load) begin
            if (v.len >= 4'd1 && v.len <= 4'd8) exp_cnt = 0;
        end else if (v.exp_out && exp_cnt < CNT_MAX) begin
            exp_cnt++;
        end
        check_outputs($sformatf("row%0d", idx), v.exp_out, v.exp_err);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = 0;

        // 1: reset defaults (1001, non-overlap), stream 1001001
        vecs.push_back(s(1,0)); vecs.push_back(s(0,0)); vecs.push_back(s(0,0));
        vecs.push_back(s(1,1)); vecs.push_back(s(0,0)); vecs.push_back(s(0,0));
        vecs.push_back(s(1,0)); vecs.push_back(idle(1));
        // 2: overlap, same stream -> hits after bits 4 and 7
        vecs.push_back(ld(8'b0000_1001, 4'd4, 1'b1, 1'b0));
        vecs.push_back(s(1,0)); vecs.push_back(s(0,0)); vecs.push_back(s(0,0));
        vecs.push_back(s(1,1)); vecs.push_back(s(0,0)); vecs.push_back(s(0,0));
        vecs.push_back(s(1,1)); vecs.push_back(idle(0));
        // 3: full-length pattern across an en=0 gap
        vecs.push_back(ld(8'b1011_0111, 4'd8, 1'b0, 1'b0));
        vecs.push_back(s(1,0)); vecs.push_back(s(0,0)); vecs.push_back(s(1,0));
        vecs.push_back(s(1,0)); vecs.push_back(s(0,0)); vecs.push_back(s(1,0));
        vecs.push_back(s(1,0));
        vecs.push_back(idle(1)); vecs.push_back(idle(0)); vecs.push_back(idle(1));
        vecs.push_back(s(1,1)); vecs.push_back(idle(1));
        // 4: reload discards a partial match
        vecs.push_back(ld(8'b0000_1001, 4'd4, 1'b0, 1'b0));
        vecs.push_back(s(1,0)); vecs.push_back(s(0,0)); vecs.push_back(s(0,0));
        vecs.push_back(ld(8'b0000_1001, 4'd4, 1'b0, 1'b0));
        vecs.push_back(s(1,0));
        vecs.push_back(s(1,0)); vecs.push_back(s(0,0)); vecs.push_back(s(0,0));
        vecs.push_back(s(1,1));
        // 5: illegal lengths rejected, config stays 1001
        vecs.push_back(ld(8'b0000_0110, 4'd0, 1'b1, 1'b1)); vecs.push_back(idle(0));
        vecs.push_back(ld(8'b1111_1111, 4'd9, 1'b1, 1'b1)); vecs.push_back(idle(0));
        vecs.push_back(s(1,0)); vecs.push_back(s(0,0)); vecs.push_back(s(0,0));
        vecs.push_back(s(1,1));
        // load and en together: load wins, the bit is dropped
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'b0000_0011, 4'd2, 1'b0, 1'b0, 1'b0));
        vecs.push_back(s(1,0)); vecs.push_back(s(1,1));
        vecs.push_back(s(1,0)); vecs.push_back(s(1,1));
        // len=1 non-overlap, pattern bits above len ignored (matches on 0)
        vecs.push_back(ld(8'b1111_1110, 4'd1, 1'b0, 1'b0));
        vecs.push_back(s(0,1)); vecs.push_back(s(1,0));
        vecs.push_back(s(0,1)); vecs.push_back(s(0,1));
        // 6: len=1, pattern 1, overlap, five ones; counter saturates at 3
        vecs.push_back(ld(8'b0000_0001, 4'd1, 1'b1, 1'b0));
        for (int k = 0; k < 5; k++) vecs.push_back(s(1,1));
        vecs.push_back(idle(1));

        // reset sequence
        rst           = 1'b0;
        en_i          = 1'b0;
        signal_i      = 1'b0;
        cfg_load_i    = 1'b0;
        cfg_pattern_i = '0;
        cfg_len_i     = '0;
        cfg_overlap_i = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_row(vecs[i], i);
        end

        // asynchronous reset while out is high
        en_i = 1'b1; signal_i = 1'b1; cfg_load_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("arst pre out", int'(out_o), 1);
        #2 rst = 1'b0;
        #1;
        exp_cnt = 0;
        check_outputs("arst async", 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_outputs("arst held", 1'b0, 1'b0);
        rst = 1'b1;

        // defaults restored: non-overlapping 1001
        vecs.delete();
        vecs.push_back(s(1,0)); vecs.push_back(s(0,0)); vecs.push_back(s(0,0));
        vecs.push_back(s(1,1)); vecs.push_back(s(0,0)); vecs.push_back(s(0,0));
        vecs.push_back(s(1,0)); vecs.push_back(idle(0));
        for (int i = 0; i < vecs.size(); i++) begin
            run_row(vecs[i], 100 + i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
